// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the divider issue front-end.
//   - RISC-V M-extension funct3 encodings for the four divide/remainder ops.
//   - FSM state type used by div_issue_ctrl.
//   - Architectural results for divide-by-zero and signed overflow at the
//     default 32-bit datapath width.
// Optional feature macro used by the files importing this package:
//   DIV_RESULT_REUSE_EN (see div_issue_ctrl.sv).
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_XLEN = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient returned for any divide by zero.
  localparam logic [DIV_XLEN-1:0] DIV0_QUOTIENT = {DIV_XLEN{1'b1}};
  // Most negative signed value; also the quotient of MIN / -1.
  localparam logic [DIV_XLEN-1:0] SIGNED_MIN    = {1'b1, {(DIV_XLEN-1){1'b0}}};

endpackage : div_pkg

// File: rtl/div_special_case.sv
// -----------------------------------------------------------------------------
// div_special_case
// Combinational detector for the two divide cases that never reach the
// divider: divide by zero and signed overflow (MIN / -1). Produces the
// architecturally defined result for whichever case applies.
//
// Ports:
//   rs1, rs2     in   XLEN  dividend / divisor
//   is_signed    in   1     DIV/REM (1) vs DIVU/REMU (0)
//   is_rem       in   1     remainder (1) vs quotient (0) requested
//   special      out  1     op is resolved locally
//   special_res  out  XLEN  result to return when special is set
// -----------------------------------------------------------------------------
module div_special_case
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            is_signed,
  input  logic            is_rem,
  output logic            special,
  output logic [XLEN-1:0] special_res
);

  // Width-generic forms of DIV0_QUOTIENT and SIGNED_MIN.
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic div_by_zero;
  logic signed_ovf;

  assign div_by_zero = (rs2 == '0);
  assign signed_ovf  = is_signed && (rs1 == MOST_NEG) && (rs2 == ALL_ONES);

  always_comb begin
    special     = div_by_zero || signed_ovf;
    special_res = '0;
    if (div_by_zero) begin
      // Remainder of x/0 is x; quotient is all-ones for both signednesses.
      special_res = is_rem ? rs1 : ALL_ONES;
    end else if (signed_ovf) begin
      special_res = is_rem ? '0 : MOST_NEG;
    end
  end

endmodule : div_special_case

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
// Sequencing front-end between execute-stage issue and the iterative divider.
// Decodes DIV/DIVU/REM/REMU, drives the divider, resolves divide-by-zero and
// signed overflow locally, and returns one tagged result per op.
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. The producer holds valid and payload stable
// until that edge; ready may be low at any time. Here op_ready is high only in
// IDLE, and res_valid is high only in DONE with res_data/res_tag held stable
// until res_ready.
//
// FSM: IDLE -> (special or reuse hit) DONE | BUSY ; BUSY -> DONE on
// div_data_valid ; DONE -> IDLE on res_ready. flush forces IDLE from any
// state and wins over a same-cycle accept or divider completion.
//
// Ports:
//   clock, reset_n              clock (rising) / async active-low reset
//   op_valid/op_ready           issue handshake
//   op_funct3, op_rs1, op_rs2   op code and operands
//   op_tag                      destination tag
//   flush                       discard in-flight op and pending result
//   div_input_a/b, div_signed_a/b, div_enable   to divider
//   div_quotient, div_remainder, div_data_valid from divider
//   res_valid/res_ready         result handshake
//   res_data, res_tag           result payload
//   state_dbg                   current FSM state (div_state_t encoding)
//
// Optional feature macro: DIV_RESULT_REUSE_EN
//   Caches the last divider quotient/remainder with its operands and
//   signedness so a matching op (e.g. REM after DIV) completes without the
//   divider.
// -----------------------------------------------------------------------------
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_funct3,
  input  logic [XLEN-1:0]  op_rs1,
  input  logic [XLEN-1:0]  op_rs2,
  input  logic [TAG_W-1:0] op_tag,
  input  logic             flush,
  output logic [XLEN-1:0]  div_input_a,
  output logic [XLEN-1:0]  div_input_b,
  output logic             div_signed_a,
  output logic             div_signed_b,
  output logic             div_enable,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder,
  input  logic             div_data_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [1:0]       state_dbg
);

  div_state_t state;
  div_state_t state_nxt;

  logic            is_rem_q;
  logic            accept;
  logic            acc_is_rem;
  logic            acc_is_signed;
  logic            spec_hit;
  logic [XLEN-1:0] spec_res;
  logic            div_done;
  logic [XLEN-1:0] div_pick;
  logic            reuse_hit;
  logic [XLEN-1:0] reuse_res;

  // funct3[2] is always 1 for the codes presented here.
  logic unused_f3;
  assign unused_f3 = op_funct3[2];

  // Outputs are pure state decodes, so reset drops div_enable immediately.
  assign op_ready   = (state == IDLE);
  assign div_enable = (state == BUSY);
  assign res_valid  = (state == DONE);
  assign state_dbg  = state;

  assign accept        = op_valid && op_ready && !flush;
  assign acc_is_rem    = op_funct3[1];
  assign acc_is_signed = ~op_funct3[0];

  // Capture of a divider result; data_valid outside BUSY is ignored.
  assign div_done = (state == BUSY) && div_data_valid && !flush;
  assign div_pick = is_rem_q ? div_remainder : div_quotient;

  div_special_case #(
    .XLEN (XLEN)
  ) u_special (
    .rs1         (op_rs1),
    .rs2         (op_rs2),
    .is_signed   (acc_is_signed),
    .is_rem      (acc_is_rem),
    .special     (spec_hit),
    .special_res (spec_res)
  );

`ifdef DIV_RESULT_REUSE_EN
  logic            cache_valid;
  logic [XLEN-1:0] cache_a;
  logic [XLEN-1:0] cache_b;
  logic            cache_signed;
  logic [XLEN-1:0] cache_q;
  logic [XLEN-1:0] cache_r;

  assign reuse_hit = cache_valid && (cache_a == op_rs1) && (cache_b == op_rs2) &&
                     (cache_signed == acc_is_signed);
  assign reuse_res = acc_is_rem ? cache_r : cache_q;

  // Only divider completions fill the cache, so it never holds a special case.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cache_valid  <= 1'b0;
      cache_a      <= '0;
      cache_b      <= '0;
      cache_signed <= 1'b0;
      cache_q      <= '0;
      cache_r      <= '0;
    end else if (flush) begin
      cache_valid  <= 1'b0;
    end else if (div_done) begin
      cache_valid  <= 1'b1;
      cache_a      <= div_input_a;
      cache_b      <= div_input_b;
      cache_signed <= div_signed_a;
      cache_q      <= div_quotient;
      cache_r      <= div_remainder;
    end
  end
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = '0;
`endif

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = (spec_hit || reuse_hit) ? DONE : BUSY;
        BUSY: if (div_data_valid) state_nxt = DONE;
        DONE: if (res_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand registers load only on accept, which happens only in IDLE, so the
  // divider inputs stay stable throughout BUSY.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_input_a  <= '0;
      div_input_b  <= '0;
      div_signed_a <= 1'b0;
      div_signed_b <= 1'b0;
      is_rem_q     <= 1'b0;
      res_tag      <= '0;
    end else if (accept) begin
      div_input_a  <= op_rs1;
      div_input_b  <= op_rs2;
      div_signed_a <= acc_is_signed;
      div_signed_b <= acc_is_signed;
      is_rem_q     <= acc_is_rem;
      res_tag      <= op_tag;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      res_data <= '0;
    end else if (accept && spec_hit) begin
      res_data <= spec_res;
    end else if (accept && reuse_hit) begin
      res_data <= reuse_res;
    end else if (div_done) begin
      res_data <= div_pick;
    end
  end

endmodule : div_issue_ctrl

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
// Directed test of div_issue_ctrl against a behavioural divider with
// programmable latency. Expected results are hand-computed constants.
// Define DIV_RESULT_REUSE_EN to exercise the result-reuse build.
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clock;
  logic             reset_n;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_funct3;
  logic [XLEN-1:0]  op_rs1;
  logic [XLEN-1:0]  op_rs2;
  logic [TAG_W-1:0] op_tag;
  logic             flush;
  logic [XLEN-1:0]  div_input_a;
  logic [XLEN-1:0]  div_input_b;
  logic             div_signed_a;
  logic             div_signed_b;
  logic             div_enable;
  logic [XLEN-1:0]  div_quotient;
  logic [XLEN-1:0]  div_remainder;
  logic             div_data_valid;
  logic             res_valid;
  logic             res_ready;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  div_issue_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .op_funct3      (op_funct3),
    .op_rs1         (op_rs1),
    .op_rs2         (op_rs2),
    .op_tag         (op_tag),
    .flush          (flush),
    .div_input_a    (div_input_a),
    .div_input_b    (div_input_b),
    .div_signed_a   (div_signed_a),
    .div_signed_b   (div_signed_b),
    .div_enable     (div_enable),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .div_data_valid (div_data_valid),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_tag        (res_tag),
    .state_dbg      (state_dbg)
  );

  // ---------------- behavioural divider ----------------
  int   div_lat = 4;
  int   div_cnt;
  logic model_dv;
  logic dv_force;

  assign div_data_valid = model_dv | dv_force;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt       <= 0;
      model_dv      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      model_dv <= 1'b0;
      if (div_enable && !model_dv) begin
        if (div_cnt >= div_lat) begin
          div_cnt  <= 0;
          model_dv <= 1'b1;
          if (div_input_b == '0) begin
            div_quotient  <= '1;
            div_remainder <= div_input_a;
          end else if (div_signed_a) begin
            div_quotient  <= $unsigned($signed(div_input_a) / $signed(div_input_b));
            div_remainder <= $unsigned($signed(div_input_a) % $signed(div_input_b));
          end else begin
            div_quotient  <= div_input_a / div_input_b;
            div_remainder <= div_input_a % div_input_b;
          end
        end else begin
          div_cnt <= div_cnt + 1;
        end
      end else begin
        div_cnt <= 0;
      end
    end
  end

  // Activity monitors (read-only by the stimulus).
  int en_cnt = 0;
  int rv_cnt = 0;
  always @(posedge clock) begin
    if (div_enable) en_cnt <= en_cnt + 1;
    if (res_valid)  rv_cnt <= rv_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  logic [XLEN-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    @(negedge clock);
    op_valid  = 1'b1;
    op_funct3 = f3;
    op_rs1    = a;
    op_rs2    = b;
    op_tag    = tag;
    @(posedge clock);
    #1;
    op_valid  = 1'b0;
  endtask

  // Issues an op, waits for its result and drains it through the handshake.
  // fast=1: result must appear one cycle after accept with no divider use.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_data, input bit fast);
    int lat;
    int en_base;
    logic [31:0] exp_d;
    exp_q.push_back(exp_data);
    en_base = en_cnt;
    issue(f3, a, b, tag);
    lat = 1;
    while (!res_valid && lat < 200) begin
      @(posedge clock);
      #1;
      lat++;
    end
    exp_d = exp_q.pop_front();
    check_eq({name, "_valid"}, {31'd0, res_valid}, 32'd1);
    check_eq({name, "_data"}, res_data, exp_d);
    check_eq({name, "_tag"}, {27'd0, res_tag}, {27'd0, tag});
    if (fast) begin
      check_eq({name, "_lat"}, lat, 1);
      check_eq({name, "_no_en"}, en_cnt - en_base, 0);
    end else begin
      check_eq({name, "_used_div"}, {31'd0, (en_cnt - en_base) > 0}, 32'd1);
    end
    repeat (2) @(posedge clock);
    #1;
    check_eq({name, "_hold_v"}, {31'd0, res_valid}, 32'd1);
    check_eq({name, "_hold_d"}, res_data, exp_d);
    @(negedge clock);
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    res_ready = 1'b0;
    check_eq({name, "_drained"}, {31'd0, res_valid}, 32'd0);
    check_eq({name, "_idle"}, {31'd0, op_ready}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rv_base;
    reset_n   = 1'b0;
    op_valid  = 1'b0;
    op_funct3 = F3_DIVU;
    op_rs1    = '0;
    op_rs2    = '0;
    op_tag    = '0;
    flush     = 1'b0;
    res_ready = 1'b0;
    dv_force  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);

    // Reset state.
    check_eq("rst_op_ready", {31'd0, op_ready}, 32'd1);
    check_eq("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check_eq("rst_div_en", {31'd0, div_enable}, 32'd0);
    check_eq("rst_in_a", div_input_a, 32'd0);
    check_eq("rst_in_b", div_input_b, 32'd0);
    check_eq("rst_signed", {30'd0, div_signed_a, div_signed_b}, 32'd0);
    check_eq("rst_res_data", res_data, 32'd0);
    check_eq("rst_res_tag", {27'd0, res_tag}, 32'd0);
    check_eq("rst_state", {30'd0, state_dbg}, 32'd0);
    reset_n = 1'b1;

    // Unsigned divide through the divider.
    div_lat = 4;
    run_op("divu", F3_DIVU, 32'd15634654, 32'd21354, 5'd3, 32'd732, 1'b0);
    run_op("remu", F3_REMU, 32'd15634654, 32'd21354, 5'd4, 32'd3526, 1'b0);

    // Signed divide: check divider drive right after accept.
    issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6);
    check_eq("sdiv_busy_en", {31'd0, div_enable}, 32'd1);
    check_eq("sdiv_signed", {30'd0, div_signed_a, div_signed_b}, 32'd3);
    check_eq("sdiv_in_a", div_input_a, 32'hFFFF_FFF9);
    check_eq("sdiv_in_b", div_input_b, 32'd2);
    check_eq("sdiv_no_ready", {31'd0, op_ready}, 32'd0);
    repeat (20) begin
      if (!res_valid) begin
        @(posedge clock);
        #1;
      end
    end
    check_eq("sdiv_data", res_data, 32'hFFFF_FFFD);
    check_eq("sdiv_en_drop", {31'd0, div_enable}, 32'd0);
    @(negedge clock);
    res_ready = 1'b1;
    @(posedge clock);
    #1;
    res_ready = 1'b0;
    run_op("srem", F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 1'b0);

    // Divide by zero.
    run_op("divu0", F3_DIVU, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b1);
    run_op("remu0", F3_REMU, 32'd5, 32'd0, 5'd9, 32'd5, 1'b1);
    run_op("div0", F3_DIV, 32'hFFFF_FFF0, 32'd0, 5'd10, DIV0_QUOTIENT, 1'b1);

    // Signed overflow.
    run_op("ovf_div", F3_DIV, SIGNED_MIN, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b1);
    run_op("ovf_rem", F3_REM, SIGNED_MIN, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b1);

    // Stray divider valid in IDLE is ignored.
    @(negedge clock);
    dv_force = 1'b1;
    @(negedge clock);
    dv_force = 1'b0;
    check_eq("stray_dv_valid", {31'd0, res_valid}, 32'd0);
    check_eq("stray_dv_ready", {31'd0, op_ready}, 32'd1);

    // Flush two cycles into BUSY.
    div_lat = 10;
    issue(F3_DIVU, 32'd1000, 32'd3, 5'd5);
    check_eq("fl_busy", {31'd0, div_enable}, 32'd1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check_eq("fl_en_low", {31'd0, div_enable}, 32'd0);
    check_eq("fl_no_valid", {31'd0, res_valid}, 32'd0);
    check_eq("fl_idle", {31'd0, op_ready}, 32'd1);
    rv_base = rv_cnt;
    repeat (15) @(posedge clock);
    #1;
    check_eq("fl_no_result", rv_cnt - rv_base, 0);

    // Accept coincident with flush is ignored.
    @(negedge clock);
    op_valid  = 1'b1;
    op_funct3 = F3_DIVU;
    op_rs1    = 32'd50;
    op_rs2    = 32'd5;
    op_tag    = 5'd2;
    flush     = 1'b1;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    flush    = 1'b0;
    check_eq("fl_acc_state", {30'd0, state_dbg}, 32'd0);
    check_eq("fl_acc_en", {31'd0, div_enable}, 32'd0);

    // Post-flush op, then the matching remainder.
    div_lat = 3;
    run_op("post_fl", F3_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 1'b0);
`ifdef DIV_RESULT_REUSE_EN
    run_op("reuse_rem", F3_REMU, 32'd100, 32'd7, 5'd13, 32'd2, 1'b1);
`else
    run_op("plain_rem", F3_REMU, 32'd100, 32'd7, 5'd13, 32'd2, 1'b0);
`endif

    // Flush while a result waits in DONE.
    issue(F3_DIVU, 32'd5, 32'd0, 5'd14);
    check_eq("done_pend", {31'd0, res_valid}, 32'd1);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    check_eq("done_flushed", {31'd0, res_valid}, 32'd0);

    // Asynchronous reset mid-BUSY.
    div_lat = 20;
    issue(F3_DIVU, 32'd100, 32'd7, 5'd15);
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_en", {31'd0, div_enable}, 32'd0);
    check_eq("arst_ready", {31'd0, op_ready}, 32'd1);
    check_eq("arst_in_a", div_input_a, 32'd0);
    check_eq("arst_res_data", res_data, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Reset also clears any cached result: this one must use the divider.
    div_lat = 2;
    run_op("post_rst", F3_REMU, 32'd100, 32'd7, 5'd1, 32'd2, 1'b0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_issue_ctrl

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequencing front-end for the iterative divider in the M-extension execute path; sits between the execute-stage issue logic and the divider instance.
- Decodes DIV/DIVU/REM/REMU and drives the divider's operand, sign and enable inputs.
- Resolves divide-by-zero and signed overflow locally without starting the divider.
- Returns one tagged result per operation over a valid/ready handshake; supports pipeline flush.

Parameters:
- XLEN, 32, operand/result width; must match the divider width.
- TAG_W, 5, width of the destination-register tag carried with each op.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  issue request.
- op_ready  out  1  ctrl can accept an op this cycle.
- op_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are never presented.
- op_rs1  in  XLEN  dividend.
- op_rs2  in  XLEN  divisor.
- op_tag  in  TAG_W  destination tag.
- flush  in  1  kill in-flight op.
- div_input_a  out  XLEN  to divider input_a.
- div_input_b  out  XLEN  to divider input_b.
- div_signed_a  out  1  to divider signed_a.
- div_signed_b  out  1  to divider signed_b.
- div_enable  out  1  to divider enable.
- div_quotient  in  XLEN  from divider output_quotient.
- div_remainder  in  XLEN  from divider output_remainder.
- div_data_valid  in  1  from divider data_valid.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  XLEN  quotient or remainder.
- res_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset:
  - state = IDLE.
  - op_ready = 1; res_valid = 0; div_enable = 0.
  - div_input_a, div_input_b, div_signed_a, div_signed_b, res_data and res_tag all = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - op_ready = 1 and div_enable = 0.
  - On op_valid && op_ready (accept) with no flush: register operands, tag, is_rem = funct3[1], is_signed = ~funct3[0].
  - Divisor == 0: res_data = is_rem ? rs1 : all-ones; go to DONE next cycle (1-cycle latency).
  - Signed, rs1 == 0x8000_0000 and rs2 == all-ones: res_data = is_rem ? 0 : 0x8000_0000; go to DONE.
  - Otherwise: go to BUSY.
- BUSY:
  - div_enable = 1.
  - div_input_a, div_input_b, div_signed_a and div_signed_b are held stable for the whole operation.
  - op_ready = 0.
  - On div_data_valid: capture div_quotient or div_remainder per is_rem; go to DONE.
  - div_enable drops in the same cycle as the capture.
- DONE:
  - res_valid = 1; res_data and res_tag stay stable until res_ready.
  - On res_valid && res_ready: go to IDLE.
  - op_ready = 0 in DONE, so no back-to-back accept.
  - div_enable is always low for at least one cycle between operations.
- flush (highest priority, any state):
  - Next state = IDLE; div_enable = 0 and res_valid = 0 next cycle.
  - In-flight and pending results are discarded.
  - An accept in the same cycle as flush is ignored.
- reset_n low mid-operation: immediate return to reset values; divider enable drops asynchronously.
- Divider latency is not assumed; the ctrl waits indefinitely for div_data_valid.
- Any div_data_valid seen outside BUSY is ignored.

Optional Feature:
- Macro: DIV_RESULT_REUSE_EN.
- When defined:
  - Keep the last divider quotient and remainder with their operands and signedness in a cache with a valid bit.
  - An accepted op whose rs1, rs2 and signedness match a valid entry skips BUSY and goes to DONE next cycle with the cached value. This covers the DIV followed by REM sequence.
  - Cache is invalidated by reset_n and flush.
  - Cache is written only on divider completion, never by the special-case paths.
- When undefined: no cache registers; every non-special op goes through BUSY.

Decomposition:
- Package div_pkg holds:
  - Funct3 localparams: F3_DIV, F3_DIVU, F3_REM, F3_REMU.
  - FSM enum div_state_t {IDLE, BUSY, DONE}.
  - XLEN-wide constants DIV0_QUOTIENT (all-ones) and SIGNED_MIN (0x8000_0000).
- One sub-module: div_special_case. It is combinational: takes rs1, rs2, is_signed and is_rem; returns special flag and special result.

Test Plan:
- DIVU 15634654 / 21354 -> divider enabled, res_data = 732, res_valid held until res_ready; REMU with same operands -> 3526.
- DIV 0xFFFF_FFF9 (-7) / 2 -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF; verifies div_signed_a/b = 1.
- DIVU 5 / 0 -> res_data 0xFFFF_FFFF one cycle after accept, div_enable never asserted; REMU 5 / 0 -> 5.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM -> 0; div_enable never asserted.
- flush two cycles into BUSY -> div_enable low next cycle, no res_valid; next op DIVU 100/7 -> 14 with the correct tag.
- With DIV_RESULT_REUSE_EN: DIVU 100/7 then REMU 100/7 -> second result 2, one cycle after accept, div_enable stays low.
